// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit FIFO onto an LSB-first 8N1 UART line; define UART_TX_PARITY_EN for an even parity bit
module fifo_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int TW = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);
  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n, after_data;
  logic [TW-1:0] timer;
  logic [2:0] idx;
  logic [7:0] shift;
  logic last, load;
  assign last = timer == LAST;
  assign load = tx_en && !fifo_empty && !reset && (state == IDLE || (state == STOP && last));
  assign fifo_pop = load;
  assign tx_busy = state != IDLE;
  assign tx_done = state == STOP && last;
`ifdef UART_TX_PARITY_EN
  logic par;
  assign after_data = PARITY;
  always_ff @(posedge clk)
    if (reset) par <= 1'b0;
    else if (load) par <= ^fifo_rdata;
`else
  assign after_data = STOP;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      timer <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      timer <= (state == IDLE || last) ? '0 : timer + 1'b1;
      idx <= (state == DATA && last) ? idx + 1'b1 : idx;
      shift <= load ? fifo_rdata : (state == DATA && last) ? shift >> 1 : shift;
    end
  always_comb begin
    state_n = state;
    tx = 1'b1;
    case (state)
      IDLE: state_n = load ? START : IDLE;
      START: begin
        tx = 1'b0;
        state_n = last ? DATA : START;
      end
      DATA: begin
        tx = shift[0];
        state_n = (last && idx == 3'd7) ? after_data : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = par;
        state_n = last ? STOP : PARITY;
      end
`endif
      STOP: state_n = last ? (load ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the 8-bit push/pop FIFO.
- Drains bytes through the FIFO's pop interface: combinational read data is valid whenever the FIFO is not empty, and a one-cycle pop advances the read pointer.
- Serializes each byte onto a UART line, 8N1 by default, LSB first.
- Sits between the FIFO and the board TX pin; it is the transmit end of the debug/command UART link.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- BIT_CYCLES, CLK_FREQ/BAUD (derived localparam): clocks per bit, integer-truncated. Must be >= 2; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_en  in  1  when high, new frames may start; when low, the frame in progress completes and no further pops occur.
- fifo_empty  in  1  empty flag from the FIFO.
- fifo_rdata  in  8  FIFO pop data; valid whenever fifo_empty=0.
- fifo_pop  out  1  one-cycle pop strobe to the FIFO.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- tx_done  out  1  one-cycle pulse in the last cycle of each stop bit.

Behaviour:
- Single clock. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: tx=1, tx_busy=0, tx_done=0, fifo_pop=0; state=IDLE; bit timer, bit index and shift register = 0.
- States and transitions:
  - IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE or START.
- Load rule:
  - In IDLE, when tx_en=1 and fifo_empty=0: fifo_pop=1 for exactly that cycle, fifo_rdata is captured into the shift register in the same cycle, next state is START.
  - fifo_pop is never asserted while fifo_empty=1 or outside a load cycle.
- Latency: tx falls on the clock edge following the pop cycle, i.e. 1 clk from pop to start bit.
- Bit timing:
  - Bit timer counts 0..BIT_CYCLES-1 and is cleared on every state change.
  - Each of START, every DATA bit, PARITY and STOP drives tx for exactly BIT_CYCLES clocks.
- Line levels per state:
  - START drives tx=0.
  - DATA drives tx=shift[0]; the register shifts right at each bit end. Bit index runs 0..7; after bit 7, go to PARITY if enabled, else STOP.
  - STOP drives tx=1.
- End of frame:
  - tx_done=1 during the final STOP cycle (timer = BIT_CYCLES-1).
  - Back-to-back chaining: in that same cycle, if tx_en=1 and fifo_empty=0, perform the load (fifo_pop=1, capture) and go directly to START. The inter-frame gap is therefore zero extra cycles; frame period = 10*BIT_CYCLES (11 with parity).
  - Otherwise go to IDLE.
- tx_busy is 0 only in IDLE. It stays 1 across chained frames.
- Deasserting tx_en mid-frame has no effect on the current frame; it only blocks the next load.
- Reset mid-frame: tx returns to 1 on the next edge, state goes to IDLE, and the byte being sent is discarded. The byte was already popped, so it is lost; this is accepted.
- fifo_empty rising while the block is busy is ignored until the next load decision.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives tx = XOR of the 8 data bits (even parity) for BIT_CYCLES clocks.
  - Frame is 11 bits; tx_busy spans 11*BIT_CYCLES.
- Not defined: no PARITY state, 10-bit frame. Port list is identical in both builds.

Test Plan:
All scenarios use CLK_FREQ=1000, BAUD=100, so BIT_CYCLES=10.
1. Reset held 3 clk with fifo_empty=0 -> fifo_pop stays 0, tx=1, tx_busy=0 throughout; after release, the first pop occurs on the first post-reset cycle.
2. Single byte 0xA5, tx_en=1, FIFO goes empty after the pop -> one fifo_pop pulse; tx = 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1; each level held 10 clk. tx_done pulses at clk 100 after the pop; tx_busy high for 100 clk; state returns to IDLE.
3. FIFO holds 0x00, 0xFF, 0x3C -> three pops spaced exactly 100 clk apart, no idle gap; tx_busy continuously high for 300 clk; three tx_done pulses.
4. tx_en dropped 20 clk into the 0x55 frame with the FIFO non-empty -> 0x55 completes; no further pop; tx_busy falls after stop. Raising tx_en again causes a pop on the next cycle.
5. Reset asserted 45 clk into a frame -> tx=1 on the next edge, IDLE; no tx_done; the next byte is popped after reset release.
6. With UART_TX_PARITY_EN defined, byte 0x07 -> parity bit = 1 after the data bits; frame length 110 clk. Byte 0x03 -> parity bit = 0.
